// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - frame load handshake bundle for seg_scan_ctrl
//
// Purpose: carries one display frame (four 4-bit codes plus per-digit blank
// mask) from a producer into the scan controller's pending buffer.
//
// Signals:
//   load_valid  producer -> ctrl  new frame offered
//   load_ready  ctrl -> producer  pending buffer empty; frame taken on valid&ready
//   load_data   producer -> ctrl  digit i = load_data[4i+3:4i], digit 0 rightmost
//   load_blank  producer -> ctrl  bit i forces digit i off, captured with load_data
//
// Modports: master = frame producer, slave = seg_scan_ctrl.

interface seg_scan_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_blank;

  modport master (
    output load_valid,
    output load_data,
    output load_blank,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_blank,
    output load_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller
//
// Purpose: time-multiplexes four digits onto one shared binary-to-7-segment
// decoder. Each digit slot lasts SCAN_DIV clocks: DEAD all-off clocks followed
// by a drive phase. New frames are double-buffered (pending -> active) and
// only swapped at the frame boundary so a frame is never shown torn.
//
// Parameters:
//   SCAN_DIV  clocks per digit slot (4..65535)
//   DEAD      all-off clocks at the start of every slot (1..SCAN_DIV-2)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   load_if      slave side of the frame load handshake
//   lz_suppress  leading-zero suppression enable, sampled every cycle
//   dig_code     code for the shared decoder data input
//   dig_en_n     decoder enable, 0 = segments driven
//   dig_sel_n    active-low digit select, at most one bit low
//   frame_done   one-cycle pulse after each frame boundary

module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave load_if,
  input  logic           lz_suppress,
  output logic [3:0]     dig_code,
  output logic           dig_en_n,
  output logic [3:0]     dig_sel_n,
  output logic           frame_done
);

  typedef enum logic {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [15:0] CNT_LAST      = 16'(SCAN_DIV - 1);
  localparam logic [15:0] CNT_DEAD_LAST = 16'(DEAD - 1);

  // Scan timing state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic        w_boundary;

  // Frame buffers
  logic        r_pend_full;
  logic [15:0] r_pend_data;
  logic [3:0]  r_pend_blank;
  logic [15:0] r_act_data;
  logic [3:0]  r_act_blank;
  logic        w_accept;

  // Output registers
  logic [3:0]  r_dig_code;
  logic        r_dig_en_n;
  logic [3:0]  r_dig_sel_n;
  logic        r_frame_done;

  // Display-path helpers
  logic [3:1]  w_lz_zero;
  logic [3:0]  w_eff_blank;
  logic [3:0]  w_nibble;

  assign load_if.load_ready = ~r_pend_full;
  assign w_accept           = load_if.load_valid & ~r_pend_full;

  //--------------------------------------------------------------------------
  // FSM state register together with slot counter and digit index
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_DEAD;
      r_cnt   <= 16'd0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic. The counter spans the whole slot; DEAD occupies counts
  // 0..DEAD-1, DRIVE the rest. The digit index only advances when leaving
  // DRIVE, so it is stable for the whole drive phase.
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    case (r_state)
      ST_DEAD: begin
        if (r_cnt == CNT_DEAD_LAST) begin
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_DEAD;
          w_cnt_nxt   = 16'd0;
          w_idx_nxt   = r_idx + 2'd1;
          w_boundary  = (r_idx == 2'd3);
        end
      end
      default: begin
        w_state_nxt = ST_DEAD;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Pending / active buffers. A copy happens only when pending was already
  // full before the boundary cycle; an accept can only occur while pending is
  // empty, so a frame accepted on the boundary cycle itself waits one frame.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_full  <= 1'b0;
      r_pend_data  <= 16'd0;
      r_pend_blank <= 4'd0;
      r_act_data   <= 16'd0;
      r_act_blank  <= 4'hF;
    end else begin
      if (w_accept) begin
        r_pend_data  <= load_if.load_data;
        r_pend_blank <= load_if.load_blank;
        r_pend_full  <= 1'b1;
      end else if (w_boundary && r_pend_full) begin
        r_act_data  <= r_pend_data;
        r_act_blank <= r_pend_blank;
        r_pend_full <= 1'b0;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Leading-zero suppression: digit i (i>0) is dark when it and every digit
  // to its left are zero. Digit 0 is always shown so a zero value reads "0".
  //--------------------------------------------------------------------------
  always_comb begin
    w_lz_zero[3] = (r_act_data[15:12] == 4'd0);
    w_lz_zero[2] = w_lz_zero[3] & (r_act_data[11:8] == 4'd0);
    w_lz_zero[1] = w_lz_zero[2] & (r_act_data[7:4]  == 4'd0);
    w_eff_blank  = r_act_blank | ({w_lz_zero, 1'b0} & {4{lz_suppress}});
  end

  always_comb begin
    w_nibble = 4'd0;
    case (r_idx)
      2'd0:    w_nibble = r_act_data[3:0];
      2'd1:    w_nibble = r_act_data[7:4];
      2'd2:    w_nibble = r_act_data[11:8];
      default: w_nibble = r_act_data[15:12];
    endcase
  end

  //--------------------------------------------------------------------------
  // Registered outputs, computed from the next state so they switch on the
  // same edge as the FSM. Outside DRIVE every select is high and the decoder
  // is disabled, which gives the all-off gap between different digits.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_sel_n  <= 4'hF;
      r_dig_en_n   <= 1'b1;
      r_dig_code   <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_state_nxt == ST_DRIVE) begin
        r_dig_sel_n <= ~(4'b0001 << r_idx);
        r_dig_code  <= w_nibble;
        r_dig_en_n  <= w_eff_blank[r_idx];
      end else begin
        r_dig_sel_n <= 4'hF;
        r_dig_code  <= 4'd0;
        r_dig_en_n  <= 1'b1;
      end
    end
  end

  assign dig_code   = r_dig_code;
  assign dig_en_n   = r_dig_en_n;
  assign dig_sel_n  = r_dig_sel_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
  localparam int SD    = 8;
  localparam int DT    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lz = 1'b0;
  logic [3:0] code;
  logic [3:0] sel_n;
  logic       en_n;
  logic       fd;

  seg_scan_ctrl_if lif();

  seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD(DT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_if     (lif),
    .lz_suppress (lz),
    .dig_code    (code),
    .dig_en_n    (en_n),
    .dig_sel_n   (sel_n),
    .frame_done  (fd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: time k counts rising edges since reset release.
  int          k;
  logic [15:0] m_act_d, m_pend_d;
  logic [3:0]  m_act_b, m_pend_b;
  bit          m_pfull;
  logic        m_lz;
  bit          last_acc;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_blank(input logic [15:0] d, input logic [3:0] b, input logic l);
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = b[i] | (l && i > 0 && ((d >> (4 * i)) == 16'd0));
    return r;
  endfunction

  task automatic model_reset();
    k = 0;
    m_act_d = 16'd0;
    m_act_b = 4'hF;
    m_pend_d = 16'd0;
    m_pend_b = 4'd0;
    m_pfull = 1'b0;
    m_lz = 1'b0;
    last_acc = 1'b0;
  endtask

  task automatic check_outputs();
    int pos = k % SD;
    int slot = (k / SD) % 4;
    bit drv = (pos >= DT);
    logic [3:0] one = 4'b0001;
    logic [3:0] eb = exp_blank(m_act_d, m_act_b, m_lz);
    logic [3:0] e_sel = drv ? ~(one << slot) : 4'hF;
    logic       e_en = drv ? eb[slot] : 1'b1;
    logic [3:0] e_code = drv ? m_act_d[4 * slot +: 4] : 4'd0;
    logic       e_fd = (k > 0) && (k % FRAME == 0);
    chk("dig_sel_n", 16'(sel_n), 16'(e_sel));
    chk("dig_en_n", 16'(en_n), 16'(e_en));
    chk("dig_code", 16'(code), 16'(e_code));
    chk("frame_done", 16'(fd), 16'(e_fd));
    chk("load_ready", 16'(lif.load_ready), 16'(!m_pfull));
  endtask

  task automatic tick();
    bit acc, bnd;
    @(posedge clk);
    acc = lif.load_valid && !m_pfull;
    bnd = (k % FRAME) == FRAME - 1;
    m_lz = lz;
    if (bnd && m_pfull) begin
      m_act_d = m_pend_d;
      m_act_b = m_pend_b;
      m_pfull = 1'b0;
    end
    if (acc) begin
      m_pend_d = lif.load_data;
      m_pend_b = lif.load_blank;
      m_pfull = 1'b1;
    end
    last_acc = acc;
    k++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] b);
    int n = 0;
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    lif.load_blank = b;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 300);
    chk("accept_timeout", 16'(last_acc), 16'd1);
    lif.load_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int guard;
    lif.load_valid = 1'b0;
    lif.load_data  = 16'd0;
    lif.load_blank = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Idle scan after reset: selects cycle, display dark
    run(70);

    // Simple frame 1234
    offer(16'h1234, 4'h0);
    run(80);

    // Leading-zero suppression on and off
    lz = 1'b1;
    offer(16'h0050, 4'h0);
    run(70);
    lz = 1'b0;
    run(40);

    // Back-to-back loads, second held valid while pending is full
    offer(16'hABCD, 4'b0010);
    offer(16'h9876, 4'h0);
    run(80);

    // Accept exactly on the boundary cycle with pending empty
    guard = 0;
    while ((k % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    chk("boundary_align", 16'(k % FRAME), 16'(FRAME - 1));
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h5A5A;
    lif.load_blank = 4'h0;
    tick();
    chk("boundary_accept", 16'(last_acc), 16'd1);
    lif.load_valid = 1'b0;
    run(70);

    // Randomized frames, blanks, lz and gaps
    repeat (12) begin
      rd = 16'($urandom);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) == 0) rd[4 * i +: 4] = 4'd0;
      lz = 1'($urandom_range(0, 1));
      offer(rd, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0);
      run(int'($urandom_range(0, 40)));
    end
    run(70);

    // Asynchronous reset while digit 2 is driven
    guard = 0;
    while (!(((k / SD) % 4) == 2 && (k % SD) >= DT + 1) && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    chk("reach_digit2", 16'((k / SD) % 4), 16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sel_off", 16'(sel_n), 16'hF);
    chk("async_en_off", 16'(en_n), 16'd1);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst_n = 1'b1;
    lz = 1'b0;
    run(70);
    offer(16'h4321, 4'h0);
    run(80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000, clock cycles per digit slot (dead time plus drive); legal range 4..65535.
REQ-002 SHALL provide parameter DEAD, default 16, all-off clock cycles at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 SHALL provide port clk, input, 1, single system clock; all logic rising-edge.
REQ-004 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port load_valid, input, 1, new display frame offered.
REQ-006 SHALL provide port load_ready, output, 1, pending buffer empty, frame accepted when valid&ready.
REQ-007 SHALL provide port load_data, input, 16, four 4-bit codes; digit i = [4i+3:4i], digit 0 rightmost.
REQ-008 SHALL provide port load_blank, input, 4, per-digit force-off, bit i = digit i, captured with load_data.
REQ-009 SHALL provide port lz_suppress, input, 1, leading-zero suppression enable, quasi-static, sampled every cycle.
REQ-010 SHALL provide port dig_code, output, 4, code for the shared binary-to-7-segment decoder data input.
REQ-011 SHALL provide port dig_en_n, output, 1, decoder enable, 0 = segments driven, 1 = all segments off.
REQ-012 SHALL provide port dig_sel_n, output, 4, active-low digit select, at most one bit low.
REQ-013 SHALL provide port frame_done, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL hold two buffers (pending, active), each 16-bit data + 4-bit blank; a pending-full flag drives load_ready = ~pending_full.
REQ-015 SHALL capture load_data/load_blank into pending on valid&ready; load_ready low from the next cycle.
REQ-016 SHALL implement a 2-state FSM: DEAD (dig_sel_n=4'hF, dig_en_n=1) and DRIVE; a slot counter runs 0..SCAN_DIV-1 and a 2-bit digit index idx.
REQ-017 SHALL move DEAD->DRIVE when the counter reaches DEAD-1, and DRIVE->DEAD when it reaches SCAN_DIV-1, then clear the counter and set idx = idx+1 mod 4.
REQ-018 SHALL, in DRIVE, drive dig_sel_n with bit idx low, dig_code = active nibble idx, dig_en_n = effective blank of idx.
REQ-019 SHALL define the frame boundary as the DRIVE->DEAD transition with idx=3; frame_done SHALL pulse high for exactly the first cycle after it (idx wrap 3->0).
REQ-020 SHALL, at the frame boundary, copy pending into active and clear pending_full only if pending_full was set before that cycle; an accept on the same cycle stays in pending for the next boundary.
REQ-021 SHALL compute effective blank of digit i = active blank[i] OR (lz_suppress AND i>0 AND active nibbles i..3 all zero).
REQ-022 SHALL register all outputs; output changes coincide with FSM state/idx changes, no combinational path from inputs to outputs.
REQ-023 SHALL guarantee one DEAD interval of all-off between any two different digit selects (no ghosting).
REQ-024 SHALL give load-to-display latency of at most one full frame (4*SCAN_DIV) plus DEAD+1 cycles once load_ready is high.

Reset
REQ-025 SHALL, while rst_n=0, force FSM=DEAD, counter=0, idx=0, dig_sel_n=4'hF, dig_en_n=1, dig_code=0, frame_done=0, load_ready=1, pending_full=0, active data=0, active blank=4'hF.
REQ-026 SHALL, on reset asserted mid-slot or mid-handshake, discard pending and active contents and turn the display off within the reset cycle (asynchronous).
REQ-027 SHALL restart scanning from digit 0 with a DEAD interval on the first clk edge after rst_n deasserts.

Verification (SCAN_DIV=8, DEAD=2 unless noted)
REQ-028 Reset release, no load -> dig_sel_n cycles E,D,B,7 with 2 all-F cycles before each; dig_en_n stays 1; frame_done pulses every 32 cycles.
REQ-029 Load 16'h1234, blank 0 -> after next boundary digits 0..3 show codes 4,3,2,1 with dig_en_n=0 during each 6-cycle DRIVE; load_ready returns high the cycle after the boundary.
REQ-030 Load 16'h0050, lz_suppress=1 -> digits 3,2 blanked, digit 1 shows 5, digit 0 shows 0; with lz_suppress=0, all four enabled.
REQ-031 Load A, then load B while ready low (held valid), then boundary -> A displayed, B accepted same/next cycle, B displayed after the following boundary; no frame skipped or torn.
REQ-032 rst_n low during DRIVE of digit 2 -> dig_sel_n=4'hF, dig_en_n=1 immediately without clk; after release display dark until a new load crosses a boundary.
REQ-033 Accept on the exact boundary cycle with pending empty -> active unchanged that frame, new data shown one frame later.
